// File: rtl/pool_2_pkg.sv
// Shared constants, state encoding and address helpers for the pool_2 stage.
package pool_2_pkg;

    localparam int unsigned DATA_SIZE         = 16;
    localparam int unsigned ADDR_W            = 13;
    localparam int unsigned POOL2_DEEP        = 16;
    localparam int unsigned POOL2_INPUT       = 10;
    localparam int unsigned POOL2_OUTPUT      = 5;
    localparam int unsigned POOL2_SIZE        = 2;
    localparam int unsigned CONV2_RESULT_BASE = 5880;
    localparam int unsigned POOL2_RESULT_BASE = 7480;

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_CHECK = 5'b00010,
        S_LOAD  = 5'b00100,
        S_STORE = 5'b01000,
        S_DONE  = 5'b10000
    } state_e;

    // Read address of window element k (k[1] = row offset, k[0] = column offset).
    function automatic logic [ADDR_W-1:0] rd_addr(input logic [4:0] ch, input logic [2:0] row,
                                                  input logic [2:0] col, input logic [2:0] k);
        logic [ADDR_W-1:0] a;
        a = ADDR_W'(CONV2_RESULT_BASE)
          + ADDR_W'(ch) * ADDR_W'(POOL2_INPUT * POOL2_INPUT)
          + (ADDR_W'(row) * ADDR_W'(POOL2_SIZE) + ADDR_W'(k[1])) * ADDR_W'(POOL2_INPUT)
          + ADDR_W'(col) * ADDR_W'(POOL2_SIZE) + ADDR_W'(k[0]);
        return a;
    endfunction

    // Write address of pooled output (ch, row, col).
    function automatic logic [ADDR_W-1:0] wr_addr(input logic [4:0] ch, input logic [2:0] row,
                                                  input logic [2:0] col);
        logic [ADDR_W-1:0] a;
        a = ADDR_W'(POOL2_RESULT_BASE)
          + ADDR_W'(ch) * ADDR_W'(POOL2_OUTPUT * POOL2_OUTPUT)
          + ADDR_W'(row) * ADDR_W'(POOL2_OUTPUT)
          + ADDR_W'(col);
        return a;
    endfunction

endpackage

// File: rtl/pool_2_if.sv
// Stage handshake plus result-BRAM port A; master is the pooling engine side.
interface pool_2_if;
    import pool_2_pkg::*;

    logic                 pool_2_en;
    logic                 pool_2_finish;
    logic                 result_bram_ena;
    logic                 result_bram_wea;
    logic [ADDR_W-1:0]    result_bram_addra;
    logic [DATA_SIZE-1:0] result_bram_dina;
    logic [DATA_SIZE-1:0] result_bram_douta;

    modport master (
        input  pool_2_en, result_bram_douta,
        output pool_2_finish, result_bram_ena, result_bram_wea, result_bram_addra, result_bram_dina
    );

    modport slave (
        output pool_2_en, result_bram_douta,
        input  pool_2_finish, result_bram_ena, result_bram_wea, result_bram_addra, result_bram_dina
    );
endinterface

// File: rtl/pool_2_max_2.sv
// Combinational signed maximum of two words.
module max_2
    import pool_2_pkg::*;
(
    input  logic [DATA_SIZE-1:0] a_i,
    input  logic [DATA_SIZE-1:0] b_i,
    output logic [DATA_SIZE-1:0] max_o
);
    // Strict compare so a tie keeps a_i (the running maximum).
    assign max_o = ($signed(b_i) > $signed(a_i)) ? b_i : a_i;
endmodule

// File: rtl/pool_2.sv
// 2x2 stride-2 max pooling of 16 x 10x10 maps into 16 x 5x5 maps in the shared result BRAM.
module pool_2
    import pool_2_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    pool_2_if.master bus
);
    state_e               state_q, state_d;
    logic [4:0]           channel_q, channel_d;
    logic [2:0]           row_q, row_d;
    logic [2:0]           column_q, column_d;
    logic [2:0]           k_q, k_d;
    logic [1:0]           circle_q, circle_d;
    logic [DATA_SIZE-1:0] max_reg_q, max_reg_d;
    logic                 ena_q, ena_d;
    logic                 wea_q, wea_d;
    logic                 finish_q, finish_d;
    logic [ADDR_W-1:0]    addra_q, addra_d;
    logic [DATA_SIZE-1:0] dina_q, dina_d;
    logic [DATA_SIZE-1:0] max_cand;

    max_2 u_max_2 (
        .a_i   (max_reg_q),
        .b_i   (bus.result_bram_douta),
        .max_o (max_cand)
    );

    assign bus.result_bram_ena   = ena_q;
    assign bus.result_bram_wea   = wea_q;
    assign bus.result_bram_addra = addra_q;
    assign bus.result_bram_dina  = dina_q;
    assign bus.pool_2_finish     = finish_q;

    // Next-state and output logic; everything holds while disabled, except leaving S_DONE.
    always_comb begin
        state_d   = state_q;
        channel_d = channel_q;
        row_d     = row_q;
        column_d  = column_q;
        k_d       = k_q;
        circle_d  = circle_q;
        max_reg_d = max_reg_q;
        ena_d     = ena_q;
        wea_d     = wea_q;
        finish_d  = finish_q;
        addra_d   = addra_q;
        dina_d    = dina_q;

        if (bus.pool_2_en || state_q == S_DONE) begin
            unique case (state_q)
                S_IDLE: begin
                    channel_d = '0;
                    row_d     = '0;
                    column_d  = '0;
                    finish_d  = 1'b0;
                    state_d   = S_CHECK;
                end
                S_CHECK: begin
                    if (channel_q == 5'(POOL2_DEEP)) begin
                        ena_d    = 1'b0;
                        wea_d    = 1'b0;
                        finish_d = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        k_d      = '0;
                        circle_d = '0;
                        state_d  = S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (k_q == 3'd4) begin
                        ena_d    = 1'b0;
                        circle_d = '0;
                        state_d  = S_STORE;
                    end else begin
                        circle_d = circle_q + 2'd1;
                        if (circle_q == 2'd0) begin
                            ena_d   = 1'b1;
                            wea_d   = 1'b0;
                            addra_d = rd_addr(channel_q, row_q, column_q, k_q);
                        end
                        // Read data for the address issued three cycles ago is valid now.
                        if (circle_q == 2'd3) begin
                            max_reg_d = (k_q == 3'd0) ? bus.result_bram_douta : max_cand;
                            k_d       = k_q + 3'd1;
                        end
                    end
                end
                S_STORE: begin
                    circle_d = circle_q + 2'd1;
                    if (circle_q == 2'd0) begin
                        ena_d   = 1'b1;
                        wea_d   = 1'b1;
                        addra_d = wr_addr(channel_q, row_q, column_q);
                        dina_d  = max_reg_q;
                    end
                    if (circle_q == 2'd3) begin
                        ena_d   = 1'b0;
                        wea_d   = 1'b0;
                        state_d = S_CHECK;
                        if (column_q == 3'(POOL2_OUTPUT - 1)) begin
                            column_d = '0;
                            if (row_q == 3'(POOL2_OUTPUT - 1)) begin
                                row_d     = '0;
                                channel_d = channel_q + 5'd1;
                            end else begin
                                row_d = row_q + 3'd1;
                            end
                        end else begin
                            column_d = column_q + 3'd1;
                        end
                    end
                end
                S_DONE: begin
                    if (!bus.pool_2_en) begin
                        finish_d = 1'b0;
                        state_d  = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            channel_q <= '0;
            row_q     <= '0;
            column_q  <= '0;
            k_q       <= '0;
            circle_q  <= '0;
            max_reg_q <= '0;
            ena_q     <= 1'b0;
            wea_q     <= 1'b0;
            finish_q  <= 1'b0;
            addra_q   <= '0;
            dina_q    <= '0;
        end else begin
            state_q   <= state_d;
            channel_q <= channel_d;
            row_q     <= row_d;
            column_q  <= column_d;
            k_q       <= k_d;
            circle_q  <= circle_d;
            max_reg_q <= max_reg_d;
            ena_q     <= ena_d;
            wea_q     <= wea_d;
            finish_q  <= finish_d;
            addra_q   <= addra_d;
            dina_q    <= dina_d;
        end
    end
endmodule

// File: tb/tb_pool_2.sv
// Scoreboard bench for pool_2: BRAM model, reference max-pool model, write monitor.
module tb_pool_2;
    import pool_2_pkg::*;

    typedef struct {
        logic [12:0] addr;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_req;
    logic [15:0] mem [0:8191];
    logic [15:0] src [0:1599];
    exp_t        exp_q [$];
    int          checks   = 0;
    int          failures = 0;
    logic        wr_prev  = 1'b0;
    int          wr_run   = 0;

    pool_2_if bus ();

    pool_2 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Synchronous read-first BRAM; also applies preloads of the conv_2 region.
    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 1600; i++) mem[CONV2_RESULT_BASE + i] = src[i];
            for (int i = 0; i < 400; i++) mem[POOL2_RESULT_BASE + i] = 16'h0000;
        end
        if (bus.result_bram_ena) begin
            bus.result_bram_douta <= mem[bus.result_bram_addra];
            if (bus.result_bram_wea) mem[bus.result_bram_addra] = bus.result_bram_dina;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: pooled value is the largest signed word of the 2x2 window.
    function automatic logic [15:0] ref_max(input int c, input int r, input int col);
        int vals [4];
        int best;
        vals[0] = int'($signed(src[c*100 + (2*r)*10 + 2*col]));
        vals[1] = int'($signed(src[c*100 + (2*r)*10 + 2*col + 1]));
        vals[2] = int'($signed(src[c*100 + (2*r+1)*10 + 2*col]));
        vals[3] = int'($signed(src[c*100 + (2*r+1)*10 + 2*col + 1]));
        best = vals[0];
        foreach (vals[i]) if (vals[i] > best) best = vals[i];
        return 16'(best);
    endfunction

    task automatic push_expected();
        exp_t it;
        exp_q.delete();
        for (int c = 0; c < 16; c++)
            for (int r = 0; r < 5; r++)
                for (int col = 0; col < 5; col++) begin
                    it.addr = 13'(POOL2_RESULT_BASE + c*25 + r*5 + col);
                    it.data = ref_max(c, r, col);
                    exp_q.push_back(it);
                end
    endtask

    function automatic logic [31:0] outs();
        return {bus.pool_2_finish, bus.result_bram_ena, bus.result_bram_wea,
                bus.result_bram_addra, bus.result_bram_dina};
    endfunction

    // Monitor: each new write burst pops one expected entry; bursts must last 3 cycles.
    always @(negedge clk) begin
        exp_t it;
        if (bus.result_bram_ena && bus.result_bram_wea && !wr_prev) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL wr_unexpected actual=%0h/%0h required=none",
                         bus.result_bram_addra, bus.result_bram_dina);
            end else begin
                it = exp_q.pop_front();
                if (bus.result_bram_addra !== it.addr || bus.result_bram_dina !== it.data) begin
                    failures++;
                    $display("FAIL wr_data actual=%0h/%0h required=%0h/%0h",
                             bus.result_bram_addra, bus.result_bram_dina, it.addr, it.data);
                end
            end
        end
        if (rst) begin
            wr_run = 0;
        end else if (bus.result_bram_ena && bus.result_bram_wea) begin
            wr_run++;
        end else if (wr_run != 0) begin
            check("wr_len", 32'(wr_run), 32'd3);
            wr_run = 0;
        end
        wr_prev = bus.result_bram_ena && bus.result_bram_wea;
    end

    task automatic start_pass(input bit reload);
        rst = 1'b1;
        bus.pool_2_en = 1'b0;
        @(negedge clk);
        if (reload) begin
            load_req = 1'b1;
            @(posedge clk);
            #1 load_req = 1'b0;
        end
        push_expected();
        bus.pool_2_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Counts enabled-run edges until finish; optionally freezes or resets mid-pass.
    task automatic run_pass(input int exp_edge, input int freeze_at, input int rst_at);
        int          e       = 0;
        bit          got     = 1'b0;
        bit          rst_hit = 1'b0;
        bit          frz_bad;
        logic [31:0] snap;
        while (!got && e < 9500) begin
            @(posedge clk);
            e++;
            #1;
            if (bus.pool_2_finish) begin
                got = 1'b1;
                check("finish_edge", 32'(e), 32'(exp_edge));
            end else if (freeze_at != 0 && e == freeze_at) begin
                bus.pool_2_en = 1'b0;
                snap = outs();
                frz_bad = 1'b0;
                repeat (50) begin
                    @(posedge clk);
                    e++;
                    #1;
                    if (outs() !== snap) frz_bad = 1'b1;
                end
                check("freeze_hold", 32'(frz_bad), 32'd0);
                bus.pool_2_en = 1'b1;
            end else if (rst_at != 0 && !rst_hit && e == rst_at) begin
                rst_hit = 1'b1;
                check("store_active", {30'd0, bus.result_bram_ena, bus.result_bram_wea}, 32'd3);
                #1 rst = 1'b1;
                #1;
                check("async_rst_ena", 32'(bus.result_bram_ena), 32'd0);
                check("async_rst_wea", 32'(bus.result_bram_wea), 32'd0);
                check("async_rst_finish", 32'(bus.pool_2_finish), 32'd0);
                @(negedge clk);
                #1 rst = 1'b0;
                push_expected();
                e = 0;
            end
        end
        if (!got) check("finish_timeout", 32'(e), 32'(exp_edge));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_ramp();
        for (int c = 0; c < 16; c++)
            for (int r = 0; r < 5; r++)
                for (int col = 0; col < 5; col++)
                    check("ramp_out", 32'(mem[POOL2_RESULT_BASE + c*25 + r*5 + col]),
                          32'(c*100 + (2*r+1)*10 + 2*col + 1));
    endtask

    initial begin
        bit hs_bad;
        rst = 1'b1;
        load_req = 1'b0;
        bus.pool_2_en = 1'b0;
        bus.result_bram_douta = '0;
        #12;
        check("rst_ena", 32'(bus.result_bram_ena), 32'd0);
        check("rst_wea", 32'(bus.result_bram_wea), 32'd0);
        check("rst_finish", 32'(bus.pool_2_finish), 32'd0);
        check("rst_addra", 32'(bus.result_bram_addra), 32'd0);
        check("rst_dina", 32'(bus.result_bram_dina), 32'd0);

        // Ramp pass.
        for (int i = 0; i < 1600; i++) src[i] = 16'(i);
        start_pass(1'b1);
        run_pass(8802, 0, 0);
        check_ramp();

        // Ramp pass with a 50-cycle enable drop in the middle of a window load.
        start_pass(1'b1);
        run_pass(8852, 1000, 0);
        check_ramp();

        // Random data with negative, tie and max-at-k2 windows planted.
        for (int i = 0; i < 1600; i++) src[i] = 16'($urandom_range(0, 65535));
        src[0]  = 16'hFFF0; src[1]  = 16'hFF00; src[10] = 16'h8000; src[11] = 16'hFFFF;
        src[2]  = 16'h0123; src[3]  = 16'h0123; src[12] = 16'h0123; src[13] = 16'h0123;
        src[4]  = 16'h0001; src[5]  = 16'h0002; src[14] = 16'h7000; src[15] = 16'h0003;
        start_pass(1'b1);
        run_pass(8802, 0, 0);
        check("neg_window", 32'(mem[7480]), 32'h0000FFFF);
        check("tie_window", 32'(mem[7481]), 32'h00000123);
        check("k2_window", 32'(mem[7482]), 32'h00007000);

        // Finish handshake: hold enable, then drop it.
        hs_bad = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (!bus.pool_2_finish || bus.result_bram_ena) hs_bad = 1'b1;
        end
        check("done_hold", 32'(hs_bad), 32'd0);
        bus.pool_2_en = 1'b0;
        @(posedge clk);
        #1;
        check("finish_clear", 32'(bus.pool_2_finish), 32'd0);

        // New random data, asynchronous reset while a write is in flight, then full rerun.
        for (int i = 0; i < 1600; i++) src[i] = 16'($urandom_range(0, 65535));
        start_pass(1'b1);
        run_pass(8802, 0, 131);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
